// File: rtl/detect_high_to_low.sv
// detect_high_to_low: falling-edge detector for an asynchronous serial line.
// The input is brought into the clk domain through a SYNC_STAGES-deep
// synchronizer. It is optionally deglitched. A registered one-cycle pulse is
// emitted on high2LowSignal for every 1->0 transition of the conditioned level.
// Optional glitch filter: define DETECT_H2L_FILTER_EN to compile it in.
// With the filter compiled in, a level change is accepted only after
// FILTER_LEN consecutive differing samples.
module detect_high_to_low #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic signal,
    output logic high2LowSignal
);

    // Parameter sanity: the synchronizer needs two flops for metastability
    // settling, and the filter needs at least one confirming sample.
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("detect_high_to_low: SYNC_STAGES must be at least 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("detect_high_to_low: FILTER_LEN must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   sync_level;
    logic                   cond_level;
    logic                   prev_level;

    // Next-value wiring of the synchronizer chain: stage 0 samples the pin,
    // and every later stage copies its predecessor.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            assign sync_next[gi] = signal;
        end else begin : g_rest
            assign sync_next[gi] = sync_reg[gi-1];
        end
    end

    // Synchronizer flops. They clear to 0, so a line already high at reset
    // release looks like a rising edge and never like a falling one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= sync_next;
        end
    end

    assign sync_level = sync_reg[SYNC_STAGES-1];

`ifdef DETECT_H2L_FILTER_EN
    // The counter must be able to reach FILTER_LEN-1 before it wraps.
    localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    logic [CNT_W-1:0] filt_cnt_reg;
    logic             cond_reg;

    // Glitch filter. It counts consecutive samples that disagree with the
    // accepted level. The new level is accepted on the FILTER_LEN-th
    // disagreement. Any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_cnt_reg <= '0;
            cond_reg     <= 1'b0;
        end else if (sync_level == cond_reg) begin
            filt_cnt_reg <= '0;
        end else if (filt_cnt_reg == CNT_W'(FILTER_LEN - 1)) begin
            cond_reg     <= sync_level;
            filt_cnt_reg <= '0;
        end else begin
            filt_cnt_reg <= filt_cnt_reg + 1'b1;
        end
    end

    assign cond_level = cond_reg;
`else
    // No filter: the synchronized level is used directly.
    assign cond_level = sync_level;
`endif

    // Edge detection. prev_level lags cond_level by one cycle. The output is
    // registered, so the pulse is exactly one cycle wide and glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_level     <= 1'b0;
            high2LowSignal <= 1'b0;
        end else begin
            prev_level     <= cond_level;
            high2LowSignal <= prev_level & ~cond_level;
        end
    end

endmodule

// File: tb/tb_detect_high_to_low.sv
// Testbench for detect_high_to_low.
// Stimulus is driven on falling clock edges. A reference model works on the
// sequence of samples seen at each rising edge. It queues the edge number at
// which every pulse is due. A monitor checks the output 1 ns after every
// rising edge against the head of that queue.
// The same bench covers both builds: define DETECT_H2L_FILTER_EN for the
// filtered build.
module tb_detect_high_to_low;

    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic sig;
    logic pulse;

    int edge_cnt = 0;
    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    bit model_prev;
    bit model_acc;
    bit win[$];

    detect_high_to_low #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .signal         (sig),
        .high2LowSignal (pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model. It is called once per upcoming rising edge n, with
    // the values that edge will see.
    task automatic model(input bit r, input bit s, input int n);
        bit all_diff;
        if (!r) begin
            model_prev = 1'b0;
            model_acc  = 1'b0;
            win.delete();
            for (int i = 0; i < FILTER_LEN; i++) win.push_back(1'b0);
            // All state is cleared, so any pulse still in flight is lost.
            while (exp_q.size() > 0 && exp_q[$] >= n) void'(exp_q.pop_back());
        end else begin
`ifdef DETECT_H2L_FILTER_EN
            // The accepted level flips once the last FILTER_LEN samples all
            // disagree with it. The flip shows at the output one edge later
            // than an unfiltered fall would.
            win.push_back(s);
            if (win.size() > FILTER_LEN) void'(win.pop_front());
            all_diff = 1'b1;
            foreach (win[i]) if (win[i] == model_acc) all_diff = 1'b0;
            if (all_diff) begin
                model_acc = ~model_acc;
                if (!model_acc) exp_q.push_back(n + SYNC_STAGES + 1);
            end
`else
            all_diff = 1'b0;
            if (model_prev && !s) exp_q.push_back(n + SYNC_STAGES);
            model_prev = s;
`endif
        end
    endtask

    task automatic step(input bit r, input bit s);
        @(negedge clk);
        rst_n = r;
        sig   = s;
        model(r, s, edge_cnt + 1);
    endtask

    task automatic run(input bit r, input bit s, input int len);
        for (int i = 0; i < len; i++) step(r, s);
    endtask

    // Monitor: compare the pulse output against the scoreboard at every edge.
    initial begin
        bit exp;
        forever begin
            @(posedge clk);
            #1;
            exp = (exp_q.size() > 0 && exp_q[0] == edge_cnt);
            checks++;
            if (pulse !== exp) begin
                failures++;
                $display("FAIL pulse_check edge=%0d got=%b expected=%b", edge_cnt, pulse, exp);
            end
            if (exp) void'(exp_q.pop_front());
        end
    end

    initial begin
        int len;
        bit lvl;
        rst_n = 1'b0;
        sig   = 1'b0;
        model(1'b0, 1'b0, 1);

        // Reset with a low line, then release it: the output must stay quiet.
        run(0, 0, 10);
        run(1, 0, 90);
        // A single falling edge. The rise before it must produce no pulse.
        run(1, 1, 18);
        run(1, 0, 10);
        // A second fall, with the same latency as the first.
        run(1, 1, 10);
        run(1, 0, 20);
        // Line high during reset, then released: no pulse. A later fall pulses.
        run(0, 1, 5);
        run(1, 1, 10);
        run(1, 0, 10);
        // Reset arrives one cycle after a fall: that pulse is lost.
        run(1, 1, 10);
        step(1, 0);
        run(0, 0, 3);
        run(1, 0, 15);
        // Glitch cases: a 2-cycle low, then a 4-cycle low and an 8-cycle low.
        run(1, 1, 10);
        run(1, 0, 2);
        run(1, 1, 10);
        run(1, 0, 4);
        run(1, 1, 10);
        run(1, 0, 8);

        // Asynchronous reset during a live pulse clears the output at once.
        run(1, 1, 10);
        for (int i = 0; i < 30; i++) begin
            step(1, 0);
            if (exp_q.size() > 0 && exp_q[$] == edge_cnt + 1) break;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pulse !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_clear got=%b expected=0", pulse);
        end
        run(0, 0, 3);
        run(1, 0, 10);

        // Random runs of random length, with occasional short resets.
        for (int i = 0; i < 400; i++) begin
            len = $urandom_range(1, 8);
            lvl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) run(0, lvl, $urandom_range(1, 3));
            else run(1, lvl, len);
        end

        // Drain the pipeline, then make sure no expected pulse went missing.
        run(1, 1, 20);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_pulses got=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/detect_high_to_low.md
# detect_high_to_low

Falling-edge detector for an asynchronous serial-line input. Brings `signal` into the `clk` domain through a synchronizer chain, optionally deglitches it, and emits a one-clock pulse on `high2LowSignal` each time the conditioned level goes from 1 to 0. Sits at the front of the serial receiver, where the pulse marks a start-bit edge.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop count, minimum 2.
- `FILTER_LEN`, default 4: consecutive stable samples needed to accept a level change, minimum 1. Only used when the filter is compiled in.
- `clk` input 1: single clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `signal` input 1: asynchronous level input.
- `high2LowSignal` output 1: registered one-cycle pulse, one per accepted falling edge.

## Operation
- Synchronizer: `SYNC_STAGES` flops in series. `sync_level` is the last stage.
- Conditioned level `cond_level`:
  - Without the filter, `cond_level` = `sync_level`.
  - With the filter, `cond_level` is a register fed by a counter sized to hold `FILTER_LEN`.
  - The counter clears to 0 whenever `sync_level == cond_level`. Otherwise it increments.
  - `cond_level` takes the value of `sync_level` on the `FILTER_LEN`-th consecutive differing sample. The counter clears on that same edge.
- `prev_level` register holds `cond_level` delayed by one cycle.
- Output register: `high2LowSignal <= prev_level & ~cond_level`. It is high for exactly one cycle per 1→0 transition of `cond_level`.
- Rising edges of `cond_level` produce no output.
- Reset (`reset` = 0):
  - Asynchronously clears all synchronizer flops, `cond_level`, `prev_level`, the filter counter and `high2LowSignal` to 0.
  - `high2LowSignal` reads 0 during reset.
  - Reset values of 0 mean an input that is already high at reset release never produces a pulse.
  - Reset asserted mid-pulse or mid-filter-count aborts it immediately. A falling edge whose pulse had not yet been emitted is lost.
- Back-to-back edges: each 1→0 of `cond_level` gives its own pulse. Edges need at least 2 cycles spacing without the filter, or `FILTER_LEN` cycles each way with it. Input pulses shorter than 1 clock may be missed.

## Timing
- `signal` falls and is first captured at rising edge k (setup met).
  - Without the filter, `high2LowSignal` rises after edge k+`SYNC_STAGES` and falls after edge k+`SYNC_STAGES`+1.
  - With the filter, it rises after edge k+`SYNC_STAGES`+`FILTER_LEN`. Pulse width is still 1 cycle.
- Default latency without the filter is 2 cycles; with the filter it is 6 cycles.
- Reset deassertion: the first capture happens at the first rising edge after `reset` goes high. No pulse can occur earlier than `SYNC_STAGES`+1 edges after release.

## Configuration
- `DETECT_H2L_FILTER_EN`:
  - When defined, the glitch filter with `FILTER_LEN` is instantiated. Any excursion of `sync_level` shorter than `FILTER_LEN` cycles is ignored and produces no pulse.
  - When undefined, there is no counter and `cond_level` is wired directly to `sync_level`. `FILTER_LEN` is ignored.

## Test plan
- Clock period 10 ns. Hold `reset`=0 for 0–100 ns and `signal`=0 -> `high2LowSignal`=0 throughout, including after release.
- Release reset, raise `signal` at 1000 ns, lower it at 1180 ns. Without the filter -> exactly one pulse of 10 ns, rising 2 edges after the first capture of the low level. The rise causes no pulse.
- Raise `signal` at 1280 ns, lower it at 1380 ns -> a second single-cycle pulse, latency identical to the first.
- Drive `signal`=1 during reset, then release -> no pulse. A later fall -> one pulse.
- Assert `reset` one cycle after `signal` falls -> `high2LowSignal` stays 0 and no pulse appears after release.
- With `DETECT_H2L_FILTER_EN` and `FILTER_LEN`=4:
  - A 2-cycle low glitch on a high line -> no pulse.
  - A low lasting 4 or more cycles -> one pulse, 6 edges after first capture.
